// File: rtl/ifetch_queue_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: the NOP
// presented to decode when nothing is fetched, the fetch-entry record kept
// in the prefetch queue, and the default reset PC.
package ifetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'hE1A0_0000;  // MOV r0,r0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction-memory request/response bus. The fetch stage drives it through
// the master modport; the memory (or a bench model) uses the slave modport.
interface ifetch_queue_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: circular prefetch buffer of fetch entries with push, pop and a
// whole-queue clear (clear wins over push/pop). ifq_fifo_chk holds the
// occupancy assertions.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           push_s, pop_s, full_s;

  // Next pointer/count values; a clear empties the queue and drops push/pop.
  always_comb begin
    push_s = push_i & ~clear_i;
    pop_s  = pop_i & ~clear_i;
    full_s = (cnt_q == CW'(DEPTH));
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      rd_d  = {AW{1'b0}};
      wr_d  = {AW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else begin
      rd_d  = pop_s  ? rd_q + AW'(1'b1) : rd_q;
      wr_d  = push_s ? wr_q + AW'(1'b1) : wr_q;
      cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= {AW{1'b0}};
      wr_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  ifq_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .full_i  (full_s),
    .count_i (cnt_q)
  );
endmodule

// Occupancy assertions for ifq_fifo: the fetch credit scheme must never push
// into a full queue or pop an empty one.
module ifq_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          push_i,
  input logic          pop_i,
  input logic          full_i,
  input logic [CW-1:0] count_i
);
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push_i && full_i));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop_i && (count_i == {CW{1'b0}})));
  a_count_range:  assert property (@(posedge clk) disable iff (reset) (32'(count_i) <= 32'(DEPTH)));
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch stage feeding decode. Issues sequential word fetches
// to an in-order variable-latency memory, buffers returned words with their
// PCs, presents one instruction per cycle and discards in-flight/buffered
// work on a redirect. Optional build macro IFETCH_PERF_CNT_EN adds the
// perf_fetched / perf_dropped counters.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 RedirectValid,
  input  logic [31:0]          RedirectPC,
  ifetch_queue_if.master       imem,
  output logic [31:0]          InstrF,
  output logic [31:0]          PCPlus8,
  output logic                 InstrValidF
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_dropped
`endif
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [CW-1:0] count_s;
  fetch_entry_t  head_s, push_entry_s;
  logic [31:0]   redir_pc_s;
  logic          credit_s, req_s, issue_s, discard_s, push_s, pop_s, valid_s;

  // Handshake decode. Queued plus outstanding fetches never exceed DEPTH, so
  // every returning word has a slot. Responses owed to a redirect, and one
  // arriving in the redirect cycle itself, are discarded.
  always_comb begin
    credit_s           = (32'(count_s) + 32'(outst_q)) < 32'(DEPTH);
    req_s              = ~reset & ~RedirectValid & credit_s & (32'(outst_q) < 32'(MAX_OUTST));
    issue_s            = req_s & imem.gnt;
    discard_s          = imem.rvalid & (RedirectValid | (drop_q != {OW{1'b0}}));
    push_s             = imem.rvalid & ~discard_s;
    valid_s            = (count_s != {CW{1'b0}});
    pop_s              = valid_s & ~StallF & ~RedirectValid;
    redir_pc_s         = word_align(RedirectPC);
    push_entry_s.pc    = rpc_q;
    push_entry_s.instr = imem.rdata;
  end

  // Next fetch/response PCs and the outstanding/discard counters. On a
  // redirect every response still owed by memory becomes a discard.
  always_comb begin
    if (RedirectValid) begin
      fpc_d  = redir_pc_s;
      rpc_d  = redir_pc_s;
      drop_d = outst_q - OW'(imem.rvalid);
    end else begin
      fpc_d  = issue_s ? fpc_q + 32'd4 : fpc_q;
      rpc_d  = push_s  ? rpc_q + 32'd4 : rpc_q;
      drop_d = discard_s ? drop_q - OW'(1'b1) : drop_q;
    end
    outst_d = outst_q + OW'(issue_s) - OW'(imem.rvalid);
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      outst_q <= {OW{1'b0}};
      drop_q  <= {OW{1'b0}};
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (RedirectValid),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (count_s)
  );

  // Decode-facing view: queue head when valid, else NOP at the next expected PC.
  always_comb begin
    if (valid_s) begin
      InstrF  = head_s.instr;
      PCPlus8 = head_s.pc + 32'd8;
    end else begin
      InstrF  = NOP_INSTR;
      PCPlus8 = rpc_q + 32'd8;
    end
  end

  assign InstrValidF = valid_s;
  assign imem.req    = req_s;
  assign imem.addr   = fpc_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetched_q, dropped_q, dropped_inc_s;

  // Dropped work per cycle: discarded responses plus entries flushed by a redirect.
  always_comb begin
    if (RedirectValid) begin
      dropped_inc_s = 32'(discard_s) + 32'(count_s);
    end else begin
      dropped_inc_s = 32'(discard_s);
    end
  end

  // Free-running performance counters (wrap at 2^32).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= 32'd0;
      dropped_q <= 32'd0;
    end else begin
      fetched_q <= fetched_q + 32'(push_s);
      dropped_q <= dropped_q + dropped_inc_s;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`endif
endmodule
